// File: rtl/atomic_pkg.sv
// Shared types, constants and helpers for the LR/SC reservation unit.
// Contents: slot state enum, lock-op decode enum, AMO opcode/funct5 constants,
// a granule-extract helper and an LR/SC opcode decoder.
package atomic_pkg;

  typedef enum logic {
    RES_IDLE = 1'b0,
    RES_HELD = 1'b1
  } res_state_t;

  typedef enum logic [1:0] {
    LOAD_RESERVE    = 2'd0,
    SET_CONDITIONAL = 2'd1,
    NO_LOCK_USE     = 2'd2
  } lock_op_t;

  localparam logic [6:0] OPC_AMO = 7'b0101111;
  localparam logic [4:0] F5_LR   = 5'h02;
  localparam logic [4:0] F5_SC   = 5'h03;

  // Widest address the granule helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_ADDR_W = 64;

  // Drop the in-granule byte offset.
  function automatic logic [MAX_ADDR_W-1:0] granule_of(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           gran_bits
  );
    return addr >> gran_bits;
  endfunction

  // Classify an AMO-class instruction as LR, SC or neither.
  function automatic lock_op_t decode_lock_op(
    input logic [6:0] opcode,
    input logic [4:0] funct5
  );
    lock_op_t op;
    op = NO_LOCK_USE;
    if (opcode == OPC_AMO) begin
      if (funct5 == F5_LR) begin
        op = LOAD_RESERVE;
      end else if (funct5 == F5_SC) begin
        op = SET_CONDITIONAL;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/atomic_res_slot.sv
// One reservation slot: state, reserved granule and (optionally) a lifetime
// counter. Cross-core arbitration lives in the parent.
// Optional feature macro: ATOMIC_RES_TIMEOUT_EN (reservation timeout counter).
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   lr_i       take a new reservation on lr_gran_i (wins over clear_i)
//   lr_gran_i  granule to reserve
//   clear_i    drop the reservation (own SC or any kill)
//   held_o     slot is RES_HELD
//   gran_o     reserved granule
//   expired_c  reservation reached its lifetime this cycle (combinational)
module atomic_res_slot
  import atomic_pkg::*;
#(
  parameter int unsigned GRAN_W = 29
`ifdef ATOMIC_RES_TIMEOUT_EN
  , parameter int unsigned RES_TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lr_i,
  input  logic [GRAN_W-1:0] lr_gran_i,
  input  logic              clear_i,
  output logic              held_o,
  output logic [GRAN_W-1:0] gran_o,
  output logic              expired_c
);

  res_state_t        state_q, state_d;
  logic [GRAN_W-1:0] gran_q, gran_d;

`ifdef ATOMIC_RES_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(RES_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RES_TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Lifetime counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RES_IDLE;
      gran_q  <= '0;
    end else begin
      state_q <= state_d;
      gran_q  <= gran_d;
    end
  end

  // Next-state logic; an LR always wins over a same-cycle clear or expiry.
  always_comb begin
    state_d = state_q;
    gran_d  = gran_q;
    unique case (state_q)
      RES_IDLE: begin
        if (lr_i) begin
          state_d = RES_HELD;
          gran_d  = lr_gran_i;
        end
      end
      RES_HELD: begin
        if (lr_i) begin
          gran_d = lr_gran_i;
        end else if (clear_i || expired_c) begin
          state_d = RES_IDLE;
        end
      end
      default: state_d = RES_IDLE;
    endcase

`ifdef ATOMIC_RES_TIMEOUT_EN
    // Restart on LR, count while held, saturate at the limit.
    cnt_d = cnt_q;
    if (lr_i) begin
      cnt_d = '0;
    end else if (state_q == RES_HELD) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
`endif
  end

  // Outputs.
  always_comb begin
    held_o = (state_q == RES_HELD);
    gran_o = gran_q;
`ifdef ATOMIC_RES_TIMEOUT_EN
    expired_c = (state_q == RES_HELD) && (cnt_q == CNT_MAX);
`else
    expired_c = 1'b0;
`endif
  end

endmodule

// File: rtl/atomic_reserve_unit.sv
// LR/SC reservation tracker for NUM_CORES cores. Resolves store-conditional
// success in the request cycle and returns a registered response one cycle
// later. Reservations are killed by invalidates, other cores' stores and
// other cores' winning SCs on the same granule.
// Optional feature macro: ATOMIC_RES_TIMEOUT_EN (adds RES_TIMEOUT_CYCLES).
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   lr_valid        per-core LR commit pulse
//   sc_valid        per-core SC request pulse
//   core_addr       per-core LR/SC address, core c at [c*ADDR_W +: ADDR_W]
//   st_valid        per-core plain-store commit pulse
//   st_addr         per-core store address
//   inv_valid       coherence invalidate observed
//   inv_addr        invalidate address
//   sc_resp_valid   per-core one-cycle SC response pulse
//   sc_success      per-core SC outcome, 0 when no response
//   res_held        per-core reservation held
module atomic_reserve_unit
  import atomic_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned GRAN_BITS = 3
`ifdef ATOMIC_RES_TIMEOUT_EN
  , parameter int unsigned RES_TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_CORES-1:0]          lr_valid,
  input  logic [NUM_CORES-1:0]          sc_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES-1:0]          st_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   st_addr,
  input  logic                          inv_valid,
  input  logic [ADDR_W-1:0]             inv_addr,
  output logic [NUM_CORES-1:0]          sc_resp_valid,
  output logic [NUM_CORES-1:0]          sc_success,
  output logic [NUM_CORES-1:0]          res_held
);

  localparam int unsigned GRAN_W = ADDR_W - GRAN_BITS;

  function automatic logic [GRAN_W-1:0] gran_of_addr(input logic [ADDR_W-1:0] a);
    return GRAN_W'(granule_of(MAX_ADDR_W'(a), GRAN_BITS));
  endfunction

  logic [GRAN_W-1:0]    req_gran  [NUM_CORES];
  logic [GRAN_W-1:0]    st_gran   [NUM_CORES];
  logic [GRAN_W-1:0]    slot_gran [NUM_CORES];
  logic [GRAN_W-1:0]    inv_gran;

  logic [NUM_CORES-1:0] held;
  logic [NUM_CORES-1:0] expired;
  logic [NUM_CORES-1:0] pre_kill;
  logic [NUM_CORES-1:0] qual;
  logic [NUM_CORES-1:0] win;
  logic [NUM_CORES-1:0] sc_kill;
  logic [NUM_CORES-1:0] slot_lr;
  logic [NUM_CORES-1:0] slot_clear;

  logic [NUM_CORES-1:0] resp_valid_q, resp_valid_d;
  logic [NUM_CORES-1:0] success_q, success_d;

  assign inv_gran = gran_of_addr(inv_addr);

  // Per-core granule extraction and slot instances.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_slot
    assign req_gran[c] = gran_of_addr(core_addr[c*ADDR_W +: ADDR_W]);
    assign st_gran[c]  = gran_of_addr(st_addr[c*ADDR_W +: ADDR_W]);

    atomic_res_slot #(
      .GRAN_W(GRAN_W)
`ifdef ATOMIC_RES_TIMEOUT_EN
      , .RES_TIMEOUT_CYCLES(RES_TIMEOUT_CYCLES)
`endif
    ) u_slot (
      .CLK       (CLK),
      .RST       (RST),
      .lr_i      (slot_lr[c]),
      .lr_gran_i (req_gran[c]),
      .clear_i   (slot_clear[c]),
      .held_o    (held[c]),
      .gran_o    (slot_gran[c]),
      .expired_c (expired[c])
    );
  end

  // Kill resolution and SC arbitration, in priority order:
  // inv/store/expiry kills, then lowest-index SC win per granule,
  // then winners kill other slots on their granule.
  always_comb begin
    pre_kill = '0;
    qual     = '0;
    win      = '0;
    sc_kill  = '0;

    for (int c = 0; c < int'(NUM_CORES); c++) begin
      pre_kill[c] = expired[c] | (inv_valid && (inv_gran == slot_gran[c]));
      for (int o = 0; o < int'(NUM_CORES); o++) begin
        if (o != c && st_valid[o] && (st_gran[o] == slot_gran[c])) begin
          pre_kill[c] = 1'b1;
        end
      end
      pre_kill[c] = pre_kill[c] & held[c];
      qual[c]     = sc_valid[c] & held[c] & (slot_gran[c] == req_gran[c]) & ~pre_kill[c];
    end

    for (int c = 0; c < int'(NUM_CORES); c++) begin
      win[c] = qual[c];
      for (int j = 0; j < c; j++) begin
        if (qual[j] && (slot_gran[j] == slot_gran[c])) begin
          win[c] = 1'b0;
        end
      end
    end

    for (int c = 0; c < int'(NUM_CORES); c++) begin
      for (int o = 0; o < int'(NUM_CORES); o++) begin
        if (o != c && win[o] && (slot_gran[o] == slot_gran[c])) begin
          sc_kill[c] = 1'b1;
        end
      end
    end
  end

  // An LR sharing a cycle with its own core's SC is dropped.
  assign slot_lr    = lr_valid & ~sc_valid;
  assign slot_clear = sc_valid | pre_kill | sc_kill;

  // Response next-state.
  always_comb begin
    resp_valid_d = sc_valid;
    success_d    = win;
  end

  // Response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_valid_q <= '0;
      success_q    <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      success_q    <= success_d;
    end
  end

  assign sc_resp_valid = resp_valid_q;
  assign sc_success    = success_q;
  assign res_held      = held;

  // LR and SC from the same core in one cycle is a datapath bug.
  a_lr_sc_exclusive: assert property (@(posedge CLK) disable iff (RST)
    ((lr_valid & sc_valid) == '0))
    else $error("atomic_reserve_unit: lr_valid and sc_valid together on one core");

endmodule
